// File: rtl/ternary_serial_min.sv
// Serial balanced-ternary minimum: two N-trit words arrive MSB-first, one trit pair
// per handshake; the smaller word, the three-way compare and a sticky error flag follow.
module ternary_serial_min #(
  parameter int N_TRITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             a_trit,
  input  logic [1:0]             b_trit,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*N_TRITS-1:0]   min_word,
  output logic [1:0]             cmp,
  output logic                   err
);

  localparam int W  = 2 * N_TRITS;
  localparam int CW = $clog2(N_TRITS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N_TRITS - 1);

  typedef enum logic [0:0] {S_COLLECT = 1'b0, S_DONE = 1'b1} state_t;

  // The illegal code 11 is folded onto zero before storage and comparison.
  function automatic logic [1:0] norm_trit(input logic [1:0] t);
    logic [1:0] r;
    case (t)
      2'b00:   r = 2'b00;
      2'b01:   r = 2'b01;
      2'b10:   r = 2'b10;
      default: r = 2'b01;
    endcase
    return r;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [1:0]      r_dec;
  logic            r_err;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [W-1:0]    r_min;
  logic [1:0]      r_cmp;
  logic            r_oerr;

  logic            w_accept;
  logic            w_last;
  logic [1:0]      w_a_n;
  logic [1:0]      w_b_n;
  logic [W-1:0]    w_a_sh;
  logic [W-1:0]    w_b_sh;
  logic [1:0]      w_dec_nxt;
  logic            w_err_nxt;

  always_comb begin
    w_accept  = in_valid && (r_state == S_COLLECT);
    w_last    = (r_cnt == LAST_CNT);
    w_a_n     = norm_trit(a_trit);
    w_b_n     = norm_trit(b_trit);
    w_a_sh    = r_a << 2;
    w_a_sh[1:0] = w_a_n;
    w_b_sh    = r_b << 2;
    w_b_sh[1:0] = w_b_n;
    w_err_nxt = r_err || (a_trit == 2'b11) || (b_trit == 2'b11);
    // Codes 00 < 01 < 10 order numerically like - < 0 < +; first difference decides.
    if ((r_dec == 2'b01) && (w_a_n != w_b_n)) begin
      w_dec_nxt = (w_a_n < w_b_n) ? 2'b00 : 2'b10;
    end else begin
      w_dec_nxt = r_dec;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: begin
        if (w_accept && w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_COLLECT;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_COLLECT;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_dec       <= 2'b01;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_min       <= {N_TRITS{2'b01}};
      r_cmp       <= 2'b01;
      r_oerr      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_COLLECT);
      r_out_valid <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_a   <= w_a_sh;
        r_b   <= w_b_sh;
        r_cnt <= r_cnt + CW'(1);
        r_dec <= w_dec_nxt;
        r_err <= w_err_nxt;
        if (w_last) begin
          r_min  <= (w_dec_nxt == 2'b10) ? w_b_sh : w_a_sh;
          r_cmp  <= w_dec_nxt;
          r_oerr <= w_err_nxt;
        end
      end else if ((r_state == S_DONE) && out_ready) begin
        r_cnt <= '0;
        r_dec <= 2'b01;
        r_err <= 1'b0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign min_word  = r_min;
  assign cmp       = r_cmp;
  assign err       = r_oerr;

endmodule

// File: tb/tb_ternary_serial_min.sv
// Directed bench for ternary_serial_min (N_TRITS=4): hand-computed vectors checked
// with immediate assertions; inputs change and outputs are sampled on the falling edge.
module tb_ternary_serial_min;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] a_trit;
  logic [1:0] b_trit;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] min_word;
  logic [1:0] cmp;
  logic       err;

  int n_cmp  = 0;
  int n_fail = 0;

  ternary_serial_min #(.N_TRITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_trit(a_trit), .b_trit(b_trit), .out_valid(out_valid), .out_ready(out_ready),
    .min_word(min_word), .cmp(cmp), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends one word MSB-first; out_valid must stay low until all four trits are in.
  task automatic send_word(input logic [7:0] a, input logic [7:0] b, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_early_valid", {31'd0, out_valid}, 32'd0);
      in_valid = 1'b1;
      a_trit   = a[7-2*i -: 2];
      b_trit   = b[7-2*i -: 2];
      if (gaps) begin
        @(negedge clk);
        in_valid = 1'b0;
        a_trit   = 2'b10;
        b_trit   = 2'b00;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [7:0] mw, input logic [1:0] c,
                            input logic e);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_inrdy"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_min"},   {24'd0, min_word}, {24'd0, mw});
    chk({tag, "_cmp"},   {30'd0, cmp}, {30'd0, c});
    chk({tag, "_err"},   {31'd0, err}, {31'd0, e});
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_trit    = 2'b01;
    b_trit    = 2'b01;
    out_ready = 1'b1;
    #12;
    chk("rst_inrdy", {31'd0, in_ready}, 32'd1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_min",   {24'd0, min_word}, 32'h55);
    chk("rst_cmp",   {30'd0, cmp}, 32'd1);
    chk("rst_err",   {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // a=+0-0, b=+-++ : decided A>B on trit 2, min is B
    send_word(8'b10010001, 8'b10001010, 1'b0);
    chk_result("w1", 8'b10001010, 2'b10, 1'b0);
    @(negedge clk);
    chk("w1_inrdy_back", {31'd0, in_ready}, 32'd1);
    chk("w1_valid_drop", {31'd0, out_valid}, 32'd0);

    // equal zero words: A chosen
    send_word(8'b01010101, 8'b01010101, 1'b0);
    chk_result("eq", 8'b01010101, 2'b01, 1'b0);

    // a=-+++, b=0--- : A<B on first trit, held
    send_word(8'b00101010, 8'b01000000, 1'b0);
    chk_result("first", 8'b00101010, 2'b00, 1'b0);

    // a=+,11,0,0  b=+,0,0,- : 11 acts as zero, err set
    send_word(8'b10110101, 8'b10010100, 1'b0);
    chk_result("inv", 8'b10010100, 2'b10, 1'b1);

    // clean word clears err: a=-000, b=-00+ -> A<B
    send_word(8'b00010101, 8'b00010110, 1'b0);
    chk_result("clean", 8'b00010101, 2'b00, 1'b0);

    // gaps plus backpressure: a=0+-0, b=0+-+ -> A<B, min=A
    @(negedge clk);
    out_ready = 1'b0;
    send_word(8'b01100001, 8'b01100010, 1'b1);
    chk_result("bp", 8'b01100001, 2'b00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      a_trit   = 2'b00;
      b_trit   = 2'b10;
      @(negedge clk);
      chk_result("bp_hold", 8'b01100001, 2'b00, 1'b0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("bp_consumed", {31'd0, out_valid}, 32'd0);
    chk("bp_inrdy",    {31'd0, in_ready}, 32'd1);
    chk("bp_min_keep", {24'd0, min_word}, 32'h61);
    chk("bp_cmp_keep", {30'd0, cmp}, 32'd0);

    // stray trits during DONE must not leak into this word
    send_word(8'b10101010, 8'b10101000, 1'b0);
    chk_result("after_bp", 8'b10101000, 2'b10, 1'b0);

    // async reset after two accepted trits
    @(negedge clk);
    in_valid = 1'b1;
    a_trit   = 2'b00;
    b_trit   = 2'b10;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_inrdy", {31'd0, in_ready}, 32'd1);
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_min",   {24'd0, min_word}, 32'h55);
    chk("ar_cmp",   {30'd0, cmp}, 32'd1);
    chk("ar_err",   {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // full four accepts needed after reset: a=+0-0, b=+-++
    send_word(8'b10010001, 8'b10001010, 1'b0);
    chk_result("post_rst", 8'b10001010, 2'b10, 1'b0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
